// File: rtl/image_pkg.sv
// Shared definitions for the image streaming transmitter: default pixel width,
// transmitter state encoding and a counter-width helper.
package image_pkg;

  localparam int unsigned DefaultDataWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StHblank,
    StVblank
  } tx_state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Frame storage: one synchronous write port, one asynchronous read port, no reset.
module frame_ram #(
  parameter int unsigned Depth     = 16,
  parameter int unsigned DataWidth = 8,
  parameter int unsigned AddrW     = 4
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrW-1:0]     waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AddrW-1:0]     raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/image_stream_tx.sv
// Streams a stored frame in raster order with horizontal/vertical blanking and
// registered valid/data outputs; optional back-to-back frames in continuous mode.
module image_stream_tx
  import image_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefaultDataWidth,
  parameter int unsigned WIDTH_IMAG  = 4,
  parameter int unsigned HEIGHT_IMAG = 4,
  parameter int unsigned H_BLANK     = 2,
  parameter int unsigned V_BLANK     = 6
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             load_we,
  input  logic [clog2_min1(WIDTH_IMAG*HEIGHT_IMAG)-1:0]    load_addr,
  input  logic [DATA_WIDTH-1:0]                            load_data,
  input  logic                                             start,
  input  logic                                             cont,
  output logic                                             busy,
  output logic                                             done,
  output logic                                             o_hav,
  output logic                                             o_vav,
  output logic [DATA_WIDTH-1:0]                            o_data
);

  localparam int unsigned NumPix   = WIDTH_IMAG * HEIGHT_IMAG;
  localparam int unsigned AddrW    = clog2_min1(NumPix);
  localparam int unsigned ColW     = clog2_min1(WIDTH_IMAG);
  localparam int unsigned RowW     = clog2_min1(HEIGHT_IMAG);
  localparam int unsigned BlankMax = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int unsigned CntW     = clog2_min1(BlankMax);

  localparam logic [ColW-1:0] ColLast = ColW'(WIDTH_IMAG - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(HEIGHT_IMAG - 1);
  localparam logic [CntW-1:0] HbLast  = CntW'(H_BLANK - 1);
  localparam logic [CntW-1:0] VbLast  = CntW'(V_BLANK - 1);

  tx_state_e             state_q, state_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [ColW-1:0]       col_q, col_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  hav_q, hav_d;
  logic                  vav_q, vav_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  ram_we;
  logic [AddrW-1:0]      rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  // Writes only while idle and in range, so a frame in flight never tears.
  assign ram_we = load_we && !rst && (state_q == StIdle) && (32'(load_addr) < NumPix);

  frame_ram #(
    .Depth     (NumPix),
    .DataWidth (DATA_WIDTH),
    .AddrW     (AddrW)
  ) u_frame_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StActive;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StActive: begin
        if (col_q == ColLast) begin
          col_d   = '0;
          cnt_d   = '0;
          state_d = (row_q == RowLast) ? StVblank : StHblank;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      StHblank: begin
        if (cnt_q == HbLast) begin
          state_d = StActive;
          row_d   = row_q + 1'b1;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StVblank: begin
        if (cnt_q == VbLast) begin
          done_d  = 1'b1;
          row_d   = '0;
          col_d   = '0;
          state_d = cont ? StActive : StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so they register alongside it.
  assign rd_addr = AddrW'(row_d) * AddrW'(WIDTH_IMAG) + AddrW'(col_d);

  always_comb begin
    busy_d = (state_d != StIdle);
    hav_d  = (state_d == StActive);
    vav_d  = hav_d || (state_d == StHblank);
    data_d = hav_d ? rd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hav_q   <= 1'b0;
      vav_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hav_q   <= hav_d;
      vav_q   <= vav_d;
      data_q  <= data_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign o_hav  = hav_q;
  assign o_vav  = vav_q;
  assign o_data = data_q;

endmodule

// File: tb/tb_image_stream_tx.sv
// Self-checking bench for image_stream_tx: directed frame scenarios plus random
// stimulus against a frame-timing model; a 3x3 instance covers out-of-range writes.
module tb_image_stream_tx;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int HB = 2;
  localparam int VB = 6;
  localparam int N  = W * H;
  localparam int P  = W + HB;
  localparam int ACT_LEN = H * P - HB;
  localparam int L  = ACT_LEN + VB;

  logic       clk = 1'b0;
  logic       rst, load_we, start, cont;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic       busy, done, o_hav, o_vav;
  logic [7:0] o_data;

  logic       start2, we2;
  logic [3:0] addr2;
  logic [7:0] wdata2;
  logic       busy2, done2, hav2, vav2;
  logic [7:0] data2;

  always #5 clk = ~clk;

  image_stream_tx #(
    .DATA_WIDTH(8), .WIDTH_IMAG(W), .HEIGHT_IMAG(H), .H_BLANK(HB), .V_BLANK(VB)
  ) dut (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .start(start), .cont(cont), .busy(busy), .done(done), .o_hav(o_hav), .o_vav(o_vav),
    .o_data(o_data)
  );

  image_stream_tx #(
    .DATA_WIDTH(8), .WIDTH_IMAG(3), .HEIGHT_IMAG(3), .H_BLANK(1), .V_BLANK(5)
  ) dut2 (
    .clk(clk), .rst(rst), .load_we(we2), .load_addr(addr2), .load_data(wdata2),
    .start(start2), .cont(1'b0), .busy(busy2), .done(done2), .o_hav(hav2), .o_vav(vav2),
    .o_data(data2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame progress as an offset into the fixed frame timeline.
  logic [7:0] ram_m [N];
  bit         m_busy = 0;
  bit         m_done = 0;
  int         m_k = 0;

  int         cyc, done_cnt, done_at, pix_n;
  logic [7:0] cap [64];

  task automatic step(input bit r, input bit s, input bit c, input bit we,
                      input logic [3:0] a, input logic [7:0] d);
    bit         e_hav, e_vav;
    logic [7:0] e_data;
    rst = r; start = s; cont = c; load_we = we; load_addr = a; load_data = d;
    @(posedge clk);
    if (r) begin
      m_busy = 0; m_done = 0; m_k = 0;
    end else begin
      if (!m_busy && we && int'(a) < N) ram_m[a] = d;
      m_done = 0;
      if (m_busy) begin
        if (m_k == L - 1) begin
          m_done = 1;
          if (c) m_k = 0;
          else m_busy = 0;
        end else begin
          m_k++;
        end
      end else if (s) begin
        m_busy = 1;
        m_k = 0;
      end
    end
    @(negedge clk);
    e_vav  = m_busy && (m_k < ACT_LEN);
    e_hav  = e_vav && ((m_k % P) < W);
    e_data = e_hav ? ram_m[(m_k / P) * W + (m_k % P)] : 8'h00;
    check_eq("busy", busy, m_busy);
    check_eq("done", done, m_done);
    check_eq("o_hav", o_hav, e_hav);
    check_eq("o_vav", o_vav, e_vav);
    check_eq("o_data", o_data, e_data);
    cyc++;
    if (done === 1'b1) begin
      done_cnt++;
      done_at = cyc;
    end
    if (o_hav === 1'b1 && pix_n < 64) begin
      cap[pix_n] = o_data;
      pix_n++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'd0, 8'd0);
  endtask

  task automatic mark();
    cyc = 0; done_cnt = 0; done_at = -1; pix_n = 0;
  endtask

  initial begin
    start2 = 0; we2 = 0; addr2 = '0; wdata2 = '0;
    mark();
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 4'd3, 8'h55);
    for (int i = 0; i < N; i++) step(0, 0, 0, 1, 4'(i), 8'(i + 1));

    // Single frame from a start at cycle 0.
    mark();
    step(0, 1, 0, 0, 4'd0, 8'd0);
    idle(34);
    check_eq("single_done_cnt", done_cnt, 1);
    check_eq("single_done_at", done_at, 29);
    check_eq("single_pix_cnt", pix_n, 16);
    check_eq("single_pix0", cap[0], 8'd1);
    check_eq("single_pix15", cap[15], 8'd16);

    // Continuous mode for two frames, then drop cont for a third.
    mark();
    step(0, 1, 1, 0, 4'd0, 8'd0);
    for (int t = 1; t < 57; t++) step(0, 0, 1, 0, 4'd0, 8'd0);
    idle(35);
    check_eq("cont_done_cnt", done_cnt, 3);
    check_eq("cont_done_at", done_at, 85);
    check_eq("cont_pix_cnt", pix_n, 48);
    check_eq("cont_pix16", cap[16], 8'd1);

    // Start pulse mid-frame is ignored.
    mark();
    step(0, 1, 0, 0, 4'd0, 8'd0);
    for (int t = 1; t < 35; t++) step(0, t == 10, 0, 0, 4'd0, 8'd0);
    check_eq("busy_start_done_cnt", done_cnt, 1);
    check_eq("busy_start_done_at", done_at, 29);

    // Load while busy is suppressed; load while idle lands.
    mark();
    step(0, 1, 0, 0, 4'd0, 8'd0);
    for (int t = 1; t < 35; t++) step(0, 0, 0, t == 8, 4'd5, 8'hAA);
    mark();
    step(0, 1, 0, 0, 4'd0, 8'd0);
    idle(34);
    check_eq("busy_write_pix5", cap[5], 8'd6);
    step(0, 0, 0, 1, 4'd5, 8'hAA);
    mark();
    step(0, 1, 0, 0, 4'd0, 8'd0);
    idle(34);
    check_eq("idle_write_pix5", cap[5], 8'hAA);
    step(0, 1, 0, 1, 4'd5, 8'd6);
    idle(34);

    // Reset mid-frame aborts without done, RAM survives.
    mark();
    step(0, 1, 0, 0, 4'd0, 8'd0);
    for (int t = 1; t < 12; t++) step(0, 0, 0, 0, 4'd0, 8'd0);
    step(1, 1, 1, 1, 4'd2, 8'h77);
    idle(20);
    check_eq("rst_no_done", done_cnt, 0);
    mark();
    step(0, 1, 0, 0, 4'd0, 8'd0);
    idle(34);
    check_eq("rst_pix_cnt", pix_n, 16);
    check_eq("rst_pix2", cap[2], 8'd3);
    check_eq("rst_pix15", cap[15], 8'd16);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit         r, s, c, we;
      logic [3:0] a;
      logic [7:0] d;
      r  = ($urandom_range(0, 63) == 0);
      s  = ($urandom_range(0, 7) == 0);
      c  = ($urandom_range(0, 3) == 0);
      we = ($urandom_range(0, 2) == 0);
      a  = 4'($urandom_range(0, 15));
      d  = 8'($urandom);
      // Pixel 0 is fetched in the start cycle, before a same-cycle write lands.
      if (s && we && a == 4'd0) a = 4'd1;
      step(r, s, c, we, a, d);
    end
    idle(40);

    // 3x3 instance: addresses 9..15 are out of range and must not disturb the frame.
    rst = 0; start = 0; load_we = 0;
    for (int i = 0; i < 16; i++) begin
      we2 = 1; addr2 = 4'(i); wdata2 = (i < 9) ? 8'(8'h10 + i) : 8'hEE;
      @(posedge clk); @(negedge clk);
    end
    for (int i = 9; i < 16; i++) begin
      we2 = 1; addr2 = 4'(i); wdata2 = 8'hEE;
      @(posedge clk); @(negedge clk);
    end
    we2 = 0; start2 = 1;
    @(posedge clk); @(negedge clk);
    start2 = 0;
    begin
      int n;
      n = 0;
      for (int t = 0; t < 40; t++) begin
        if (hav2 === 1'b1) begin
          if (n < 9) check_eq("oor_pix", data2, 8'(8'h10 + n));
          n++;
        end
        @(posedge clk); @(negedge clk);
      end
      check_eq("oor_pix_cnt", n, 9);
      check_eq("oor_busy_end", busy2, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
